mmio_peripherals: RTL and testbench

Memory-mapped peripheral responder on the CPU data-memory bus: decodes loads and stores in the `0x4000_0000` window and answers them from a timer, a system tick counter, an LED register and a 4-digit seven-segment scanner. It sits beside the data memory and shares the same address, write-data, read-data and strobe signals. The top level ORs its read data with the memory's read data and routes `irqout` to the control unit's IRQ input.

---
 rtl/mmio_pkg.sv | 20 ++
 rtl/mmio_peripherals_seg7.sv | 31 +++
 rtl/mmio_peripherals.sv | 119 +++++++++++
 tb/tb_mmio_peripherals.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped peripheral block.
package mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE = 32'h4000_0000;

  // Register window is 64 bytes; offsets are byte offsets within it.
  localparam int         WIN_BITS    = 6;
  localparam logic [5:0] OFF_TH      = 6'h00;
  localparam logic [5:0] OFF_TL      = 6'h04;
  localparam logic [5:0] OFF_TCON    = 6'h08;
  localparam logic [5:0] OFF_LED     = 6'h0C;
  localparam logic [5:0] OFF_DIGI    = 6'h10;
  localparam logic [5:0] OFF_SYSTICK = 6'h14;

  // TCON bit positions
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

endpackage

// File: rtl/mmio_peripherals_seg7.sv
// Hex nibble to active-low seven-segment pattern {dp,g,f,e,d,c,b,a}, dp off.
module seg7_decoder (
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  // Standard glyphs; b and d rendered lowercase.
  always_comb begin
    seg = 8'hFF;
    case (hex)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  end

endmodule

// File: rtl/mmio_peripherals.sv
// Memory-mapped timer, systick, LED register and 4-digit seven-segment scanner.
module mmio_peripherals
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE     = DEFAULT_BASE,
  parameter int          SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        irqout,
  output logic [7:0]  leds,
  output logic [3:0]  anodes,
  output logic [7:0]  cathodes
);

  localparam int             DW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);

  logic [31:0]   th, tl, systick;
  logic [2:0]    tcon;
  logic [7:0]    led;
  logic [15:0]   digi;
  logic [DW-1:0] div;
  logic [1:0]    idx;

  logic       hit, rd, wr;
  logic [5:0] off;
  logic       wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
  logic       tl_max, reload, ovf_set;

  // Address decode: word offset inside the 64-byte window, byte lanes ignored.
  assign hit = (Address[31:WIN_BITS] == BASE[31:WIN_BITS]);
  assign off = {Address[5:2], 2'b00};
  assign rd  = MemRead  & hit;
  assign wr  = MemWrite & hit;

  assign wr_th   = wr && (off == OFF_TH);
  assign wr_tl   = wr && (off == OFF_TL);
  assign wr_tcon = wr && (off == OFF_TCON);
  assign wr_led  = wr && (off == OFF_LED);
  assign wr_digi = wr && (off == OFF_DIGI);

  // A software TL write preempts both the reload and the interrupt it would raise.
  assign tl_max  = (tl == 32'hFFFF_FFFF);
  assign reload  = tcon[TCON_EN] && tl_max && !wr_tl;
  assign ovf_set = reload && tcon[TCON_IE];

  // Combinational read mux; unmapped offsets and misses read as zero.
  always_comb begin
    Read_data = 32'h0;
    if (rd) begin
      case (off)
        OFF_TH:      Read_data = th;
        OFF_TL:      Read_data = tl;
        OFF_TCON:    Read_data = {29'h0, tcon};
        OFF_LED:     Read_data = {24'h0, led};
        OFF_DIGI:    Read_data = {16'h0, digi};
        OFF_SYSTICK: Read_data = systick;
        default:     Read_data = 32'h0;
      endcase
    end
  end

  // Software-writable registers plus timer count/reload; overflow set ORs into a TCON write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th   <= 32'h0;
      tl   <= 32'h0;
      tcon <= 3'h0;
      led  <= 8'h0;
      digi <= 16'h0;
    end else begin
      if (wr_th)   th   <= Write_data;
      if (wr_led)  led  <= Write_data[7:0];
      if (wr_digi) digi <= Write_data[15:0];

      if (wr_tl)               tl <= Write_data;
      else if (reload)         tl <= th;
      else if (tcon[TCON_EN])  tl <= tl + 32'd1;

      if (wr_tcon)      tcon <= {Write_data[TCON_IS] | ovf_set, Write_data[1:0]};
      else if (ovf_set) tcon[TCON_IS] <= 1'b1;
    end
  end

  // Free-running cycle counter, read-only from the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) systick <= 32'h0;
    else       systick <= systick + 32'd1;
  end

  // Scan divider: each digit dwells SCAN_DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
      idx <= 2'd0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + DW'(1);
    end
  end

  seg7_decoder u_seg (
    .hex (digi[idx*4 +: 4]),
    .seg (cathodes)
  );

  assign anodes = ~(4'b0001 << idx);
  assign irqout = tcon[TCON_IS];
  assign leds   = led;

endmodule

// File: tb/tb_mmio_peripherals.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor drains and compares.
module tb_mmio_peripherals;
  import mmio_pkg::*;

  localparam logic [31:0] B = DEFAULT_BASE;
  localparam int K_RD = 0, K_IRQ = 1, K_LED = 2, K_AN = 3, K_CAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, Write_data, Read_data;
  logic        MemRead, MemWrite;
  logic        irqout;
  logic [7:0]  leds, cathodes;
  logic [3:0]  anodes;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   tb_cycles;

  mmio_peripherals #(.BASE(B), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Read_data  (Read_data),
    .irqout     (irqout),
    .leds       (leds),
    .anodes     (anodes),
    .cathodes   (cathodes)
  );

  always #5 clk = ~clk;

  // Reference count of edges since reset release (drives systick / scan phase expectations).
  always @(posedge clk or posedge reset)
    if (reset) tb_cycles <= 0;
    else       tb_cycles <= tb_cycles + 1;

  // Monitor: compare every pending expectation against the live outputs.
  always @(negedge clk) begin : mon
    chk_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD:    act = Read_data;
        K_IRQ:   act = {31'h0, irqout};
        K_LED:   act = {24'h0, leds};
        K_AN:    act = {28'h0, anodes};
        default: act = {24'h0, cathodes};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_out(input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.kind = kind; c.exp = exp; c.name = name;
    sb.push_back(c);
  endtask

  task automatic step();
    @(posedge clk); #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    Address = a; Write_data = d; MemWrite = 1'b1; MemRead = 1'b0;
    step();
  endtask

  // Drives a read for the current cycle; the caller steps.
  task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    Address = a; MemRead = 1'b1;
    expect_out(K_RD, exp, name);
  endtask

  task automatic idle_outputs(input string tag);
    expect_out(K_IRQ, 32'h0,  {tag, " irqout"});
    expect_out(K_LED, 32'h0,  {tag, " leds"});
    expect_out(K_AN,  32'hE,  {tag, " anodes"});
    expect_out(K_CAT, 32'hC0, {tag, " cathodes"});
  endtask

  logic [7:0] glyph [4];
  logic [3:0] an_tbl [4];

  initial begin
    glyph[0] = 8'h8E; glyph[1] = 8'hB0; glyph[2] = 8'h88; glyph[3] = 8'hF9;
    an_tbl[0] = 4'hE; an_tbl[1] = 4'hD; an_tbl[2] = 4'hB; an_tbl[3] = 4'h7;
    reset = 1'b1; Address = 32'h0; Write_data = 32'h0; MemRead = 1'b0; MemWrite = 1'b0;
    step();

    // Reset state, read while held in reset
    idle_outputs("reset");
    bus_rd(B + 32'h00, 32'h0, "rst TH");      step();
    bus_rd(B + 32'h04, 32'h0, "rst TL");      step();
    bus_rd(B + 32'h08, 32'h0, "rst TCON");    step();
    bus_rd(B + 32'h0C, 32'h0, "rst LED");     step();
    bus_rd(B + 32'h10, 32'h0, "rst DIGI");    step();
    bus_rd(B + 32'h14, 32'h0, "rst SYSTICK"); step();
    reset = 1'b0;
    step();

    // Timer count, reload and interrupt
    bus_wr(B + 32'h00, 32'd5);
    bus_wr(B + 32'h04, 32'hFFFF_FFFD);
    bus_wr(B + 32'h08, 32'd3);
    bus_rd(B + 32'h04, 32'hFFFF_FFFD, "TL t0"); expect_out(K_IRQ, 0, "irq t0"); step();
    bus_rd(B + 32'h04, 32'hFFFF_FFFE, "TL t1"); step();
    bus_rd(B + 32'h04, 32'hFFFF_FFFF, "TL t2"); expect_out(K_IRQ, 0, "irq before reload"); step();
    bus_rd(B + 32'h04, 32'd5, "TL reload");     expect_out(K_IRQ, 1, "irq at reload"); step();
    bus_rd(B + 32'h08, 32'd7, "TCON status");   step();
    expect_out(K_IRQ, 1, "irq during clear write");
    bus_wr(B + 32'h08, 32'd1);
    bus_rd(B + 32'h08, 32'd1, "TCON cleared");  expect_out(K_IRQ, 0, "irq cleared"); step();

    // Overflow coincides with a TCON write of 3: status set must survive
    bus_wr(B + 32'h08, 32'd0);
    bus_wr(B + 32'h04, 32'hFFFF_FFFE);
    bus_wr(B + 32'h08, 32'd3);
    step();
    expect_out(K_IRQ, 0, "irq pre collide");
    bus_wr(B + 32'h08, 32'd3);
    bus_rd(B + 32'h08, 32'd7, "TCON set wins"); expect_out(K_IRQ, 1, "irq set wins"); step();

    // Simultaneous read and write returns the old value
    Address = B; Write_data = 32'h1234; MemWrite = 1'b1; MemRead = 1'b1;
    expect_out(K_RD, 32'd5, "TH rd+wr old"); step();
    bus_rd(B, 32'h1234, "TH new"); step();

    // LED, decode misses and window boundary
    bus_wr(B + 32'h0C, 32'hFFFF_FFA5);
    bus_rd(B + 32'h0C, 32'hA5, "LED rd"); expect_out(K_LED, 32'hA5, "leds"); step();
    bus_wr(32'h1000_000C, 32'hFF);
    bus_rd(32'h1000_000C, 32'h0, "out of window rd"); expect_out(K_LED, 32'hA5, "leds after miss"); step();
    bus_rd(B + 32'h18, 32'h0, "unmapped 0x18"); step();
    bus_rd(B + 32'h40, 32'h0, "window end 0x40"); step();
    Address = B; MemRead = 1'b0;
    expect_out(K_RD, 32'h0, "no MemRead"); step();

    // SYSTICK read-only and counting
    bus_wr(B + 32'h14, 32'h0);
    bus_rd(B + 32'h14, tb_cycles, "SYSTICK a"); step();
    bus_rd(B + 32'h14, tb_cycles, "SYSTICK b"); step();

    // Scanner over a full scan of 1A3F
    bus_wr(B + 32'h10, 32'h1A3F);
    bus_rd(B + 32'h10, 32'h1A3F, "DIGI rd"); step();
    for (int i = 0; i < 16; i++) begin
      expect_out(K_AN,  {28'h0, an_tbl[(tb_cycles / 4) % 4]}, "scan anodes");
      expect_out(K_CAT, {24'h0, glyph[(tb_cycles / 4) % 4]},  "scan cathodes");
      step();
    end

    // Asynchronous reset mid-count/scan: outputs clear before any posedge
    expect_out(K_IRQ, 1, "irq before reset"); step();
    reset = 1'b1;
    Address = B + 32'h04; MemRead = 1'b1;
    expect_out(K_RD, 32'h0, "TL async reset");
    idle_outputs("async reset");
    step();
    reset = 1'b0;
    step();
    step();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
